// File: rtl/frame_parser_pkg.sv
// rtl/frame_parser_pkg.sv - state encoding and default patterns for the frame parser
package frame_parser_pkg;

    typedef enum logic [1:0] {HUNT, CHAN, BODY, DONE} fp_state_t;

    localparam logic [15:0] HDR_PAT_D  = 16'hE0E0;
    localparam logic [15:0] TAIL_PAT_D = 16'h0E0E;
    localparam logic [15:0] CRC_POLY_D = 16'h1021;

endpackage

// File: rtl/crc_word_step.sv
// rtl/crc_word_step.sv - one word of MSB-first CRC-16 update, purely combinational
module crc_word_step #(
    parameter int W = 16
) (
    input  logic [15:0]  crc,
    input  logic [W-1:0] word,
    input  logic [15:0]  poly,
    output logic [15:0]  next_crc
);

    always_comb begin
        next_crc = crc;
        for (int i = W - 1; i >= 0; i--) begin
            if (next_crc[15] ^ word[i]) next_crc = {next_crc[14:0], 1'b0} ^ poly;
            else                        next_crc = {next_crc[14:0], 1'b0};
        end
    end

endmodule

// File: rtl/frame_parser_mc.sv
// rtl/frame_parser_mc.sv - HDR HDR CH payload CRC TAIL TAIL parser with held result and error pulses
// Optional FRAME_PARSER_MC_STATS_EN adds good/error frame counters.
module frame_parser_mc
    import frame_parser_pkg::*;
#(
    parameter int          W         = 16,
    parameter int          MAX_WORDS = 8,
    parameter int          NUM_CH    = 16,
    parameter int          CH_W      = 8,
    parameter logic [W-1:0] HDR_PAT  = HDR_PAT_D,
    parameter logic [W-1:0] TAIL_PAT = TAIL_PAT_D,
    parameter logic [15:0] CRC_POLY  = CRC_POLY_D
) (
    input  logic                           clk_in,
    input  logic                           rst,
    input  logic [W-1:0]                   data_in,
    input  logic                           data_valid,
    output logic [MAX_WORDS*W-1:0]         out_data,
    output logic [CH_W-1:0]                out_ch,
    output logic [$clog2(MAX_WORDS+1)-1:0] out_len,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           crc_err,
    output logic                           len_err,
    output logic                           ch_err,
`ifdef FRAME_PARSER_MC_STATS_EN
    output logic [15:0]                    frame_ok_cnt,
    output logic [15:0]                    frame_err_cnt,
`endif
    output logic                           ovf_err
);

    localparam int PW = MAX_WORDS * W;
    localparam int LW = $clog2(MAX_WORDS + 1);
    localparam logic [LW-1:0] MAX_L = LW'(MAX_WORDS);

    fp_state_t         state;
    logic              hdr_seen;
    logic [2:0][W-1:0] dl;
    logic [1:0]        fill;
    logic [15:0]       crc_q;
    logic [LW-1:0]     cnt_q;
    logic [PW-1:0]     pay_q;
    logic [CH_W-1:0]   ch_q;

    logic [15:0]   crc_step, crc_nx;
    logic [LW-1:0] cnt_nx;
    logic [PW-1:0] pay_nx, pay_word;
    logic body_acc, leave, over, tail_hit, ch_bad;
    logic ev_tail, ev_len, ev_ch, ev_crc, ev_good, ev_ovf, ev_load;

    // The oldest delay-line word is the one that becomes payload; align it to the MSB end.
    assign pay_word = {dl[2], {(PW-W){1'b0}}};

    crc_word_step #(.W(W)) u_crc_step (
        .crc      (crc_q),
        .word     (dl[2]),
        .poly     (CRC_POLY),
        .next_crc (crc_step)
    );

    always_comb begin
        body_acc = (state == BODY) && data_valid;
        leave    = body_acc && (fill == 2'd3);
        over     = leave && (cnt_q == MAX_L);
        crc_nx   = crc_q;
        cnt_nx   = cnt_q;
        pay_nx   = pay_q;
        if (leave && !over) begin
            crc_nx = crc_step;
            cnt_nx = cnt_q + LW'(1);
            pay_nx = pay_q | (pay_word >> (W * int'(cnt_q)));
        end
        tail_hit = (data_in == TAIL_PAT) && (fill != 2'd0) && (dl[0] == TAIL_PAT);
        ch_bad   = 32'(ch_q) >= NUM_CH;
        // Overflow on the tail edge itself still counts as a length error, not a tail.
        ev_tail  = body_acc && tail_hit && !over;
        ev_len   = (body_acc && over) || (ev_tail && cnt_nx == '0);
        ev_ch    = ev_tail && (cnt_nx != '0) && ch_bad;
        ev_crc   = ev_tail && (cnt_nx != '0) && !ch_bad && (crc_nx != 16'(dl[1]));
        ev_good  = ev_tail && (cnt_nx != '0) && !ch_bad && (crc_nx == 16'(dl[1]));
        ev_ovf   = ev_good && out_valid && !out_ready;
        ev_load  = ev_good && !(out_valid && !out_ready);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= HUNT;
            hdr_seen  <= 1'b0;
            dl        <= '0;
            fill      <= 2'd0;
            crc_q     <= '0;
            cnt_q     <= '0;
            pay_q     <= '0;
            ch_q      <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_len   <= '0;
            out_valid <= 1'b0;
            crc_err   <= 1'b0;
            len_err   <= 1'b0;
            ch_err    <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            crc_err <= ev_crc;
            len_err <= ev_len;
            ch_err  <= ev_ch;
            ovf_err <= ev_ovf;
            if (ev_load) begin
                out_valid <= 1'b1;
                out_data  <= pay_nx;
                out_ch    <= ch_q;
                out_len   <= cnt_nx;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                HUNT: if (data_valid) begin
                    if (hdr_seen && data_in == HDR_PAT) begin
                        state    <= CHAN;
                        hdr_seen <= 1'b0;
                    end else begin
                        hdr_seen <= (data_in == HDR_PAT);
                    end
                end
                CHAN: if (data_valid) begin
                    ch_q  <= data_in[CH_W-1:0];
                    state <= BODY;
                    fill  <= 2'd0;
                    crc_q <= '0;
                    cnt_q <= '0;
                    pay_q <= '0;
                end
                BODY: if (data_valid) begin
                    dl    <= {dl[1], dl[0], data_in};
                    fill  <= (fill == 2'd3) ? fill : fill + 2'd1;
                    crc_q <= crc_nx;
                    cnt_q <= cnt_nx;
                    pay_q <= pay_nx;
                    if (over)          state <= HUNT;
                    else if (tail_hit) state <= DONE;
                end
                default: state <= HUNT;
            endcase
        end
    end

`ifdef FRAME_PARSER_MC_STATS_EN
    always_ff @(posedge clk_in) begin
        if (rst) begin
            frame_ok_cnt  <= '0;
            frame_err_cnt <= '0;
        end else begin
            if (ev_load) frame_ok_cnt <= frame_ok_cnt + 16'd1;
            if (ev_len | ev_ch | ev_crc | ev_ovf) frame_err_cnt <= frame_err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_parser_mc.sv
// tb/tb_frame_parser_mc.sv - directed and randomized frames checked against a frame-level model
`timescale 1ns/1ps
module tb_frame_parser_mc;

    localparam logic [15:0] HDR  = 16'hE0E0;
    localparam logic [15:0] TAIL = 16'h0E0E;

    logic         clk_in = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  data_in = '0;
    logic         data_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic [7:0]   out_ch;
    logic [3:0]   out_len;
    logic         out_valid, crc_err, len_err, ch_err, ovf_err;
`ifdef FRAME_PARSER_MC_STATS_EN
    logic [15:0]  frame_ok_cnt, frame_err_cnt;
`endif

    frame_parser_mc dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_len    (out_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .crc_err    (crc_err),
        .len_err    (len_err),
        .ch_err     (ch_err),
`ifdef FRAME_PARSER_MC_STATS_EN
        .frame_ok_cnt  (frame_ok_cnt),
        .frame_err_cnt (frame_err_cnt),
`endif
        .ovf_err    (ovf_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [127:0] d;
        logic [7:0]   ch;
        logic [3:0]   len;
    } res_t;

    res_t        got_q[$];
    int          n_crc, n_len, n_ch, n_ovf, n_vcyc, n_rsterr;
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] cur_ch;
    logic [15:0] pl_q[$];
    logic [15:0] crc_x;

    always @(negedge clk_in) begin
        if (rst) begin
            if ((crc_err | len_err | ch_err | ovf_err) === 1'b1) n_rsterr++;
        end else begin
            n_crc += int'(crc_err === 1'b1);
            n_len += int'(len_err === 1'b1);
            n_ch  += int'(ch_err === 1'b1);
            n_ovf += int'(ovf_err === 1'b1);
            if (out_valid === 1'b1) n_vcyc++;
            if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back({out_data, out_ch, out_len});
        end
    end

    function automatic logic [15:0] model_crc();
        logic [15:0] c = '0;
        foreach (pl_q[i])
            for (int b = 15; b >= 0; b--)
                c = (c[15] ^ pl_q[i][b]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        return c;
    endfunction

    // 0 good, 1 length, 2 channel, 3 crc
    function automatic int model_kind();
        if (pl_q.size() == 0 || pl_q.size() > 8) return 1;
        if (cur_ch[7:0] >= 8'd16) return 2;
        if (crc_x != 16'h0) return 3;
        return 0;
    endfunction

    function automatic res_t model_res();
        res_t r;
        r.d   = '0;
        r.ch  = cur_ch[7:0];
        r.len = 4'(pl_q.size());
        foreach (pl_q[i]) r.d[127-16*i -: 16] = pl_q[i];
        return r;
    endfunction

    task automatic push(input logic [15:0] w, input bit stall);
        data_in = w;
        data_valid = 1'b1;
        @(posedge clk_in); #1;
        data_valid = 1'b0;
        if (stall) begin
            @(posedge clk_in); #1;
        end
    endtask

    task automatic send_frame(input bit stall, input bit ready_last);
        logic [15:0] fw[$];
        fw = {HDR, HDR, cur_ch};
        foreach (pl_q[i]) fw.push_back(pl_q[i]);
        fw.push_back(model_crc() ^ crc_x);
        fw.push_back(TAIL);
        fw.push_back(TAIL);
        foreach (fw[i]) begin
            if (ready_last && i == fw.size() - 1) out_ready = 1'b1;
            push(fw[i], stall);
        end
    endtask

    task automatic idle(input int n);
        data_valid = 1'b0;
        repeat (n) begin
            @(posedge clk_in); #1;
        end
    endtask

    task automatic clear_mon();
        n_crc = 0; n_len = 0; n_ch = 0; n_ovf = 0; n_vcyc = 0; n_rsterr = 0;
        got_q.delete();
    endtask

    task automatic test_reset();
        clear_mon();
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk_in); #1;
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        vectors++; if (out_data !== 128'h0 || out_ch !== 8'h0 || out_len !== 4'h0) begin
            miscompares++; $display("FAIL reset_outputs got data=%h ch=%h len=%0d exp all zero", out_data, out_ch, out_len); end
        vectors++; if ({crc_err, len_err, ch_err, ovf_err} !== 4'b0 || n_rsterr != 0) begin
            miscompares++; $display("FAIL reset_err_pulses got=%b count=%0d exp=0", {crc_err, len_err, ch_err, ovf_err}, n_rsterr); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_good();
        res_t ea;
        clear_mon(); out_ready = 1'b1;
        cur_ch = 16'h0003; pl_q = {16'h1234, 16'h5678}; crc_x = 16'h0;
        ea = model_res();
        send_frame(1'b0, 1'b0);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL good_valid_latency got=%b exp=1", out_valid); end
        vectors++; if (out_ch !== 8'h03) begin miscompares++; $display("FAIL good_ch got=%h exp=03", out_ch); end
        vectors++; if (out_len !== 4'd2) begin miscompares++; $display("FAIL good_len got=%0d exp=2", out_len); end
        vectors++; if (out_data !== {32'h12345678, 96'h0}) begin miscompares++; $display("FAIL good_data got=%h exp=%h", out_data, {32'h12345678, 96'h0}); end
        idle(5);
        vectors++; if (n_vcyc != 1 || got_q.size() != 1) begin miscompares++; $display("FAIL good_one_cycle got cycles=%0d results=%0d exp=1/1", n_vcyc, got_q.size()); end
        else begin vectors++; if (got_q[0] !== ea) begin miscompares++; $display("FAIL good_result got=%h exp=%h", got_q[0], ea); end end
        vectors++; if (n_crc + n_len + n_ch + n_ovf != 0) begin miscompares++; $display("FAIL good_no_err got=%0d exp=0", n_crc + n_len + n_ch + n_ovf); end
    endtask

    task automatic test_crc_err();
        clear_mon();
        cur_ch = 16'h0003; pl_q = {16'h1234, 16'h5678}; crc_x = 16'h0001;
        send_frame(1'b0, 1'b0); idle(5);
        vectors++; if (n_crc != 1 || n_len + n_ch + n_ovf != 0) begin miscompares++; $display("FAIL crc_err_pulse got crc=%0d other=%0d exp=1/0", n_crc, n_len + n_ch + n_ovf); end
        vectors++; if (n_vcyc != 0) begin miscompares++; $display("FAIL crc_err_no_valid got=%0d exp=0", n_vcyc); end
    endtask

    task automatic test_ch_len();
        clear_mon();
        cur_ch = 16'h0010; pl_q = {16'h1234, 16'h5678}; crc_x = 16'h0;
        send_frame(1'b0, 1'b0); idle(4);
        vectors++; if (n_ch != 1 || n_crc + n_len + n_ovf != 0 || n_vcyc != 0) begin
            miscompares++; $display("FAIL ch_err_pulse got ch=%0d other=%0d valid=%0d exp=1/0/0", n_ch, n_crc + n_len + n_ovf, n_vcyc); end
        clear_mon();
        cur_ch = 16'h0003; pl_q = {};
        send_frame(1'b0, 1'b0); idle(4);
        vectors++; if (n_len != 1 || n_crc + n_ch + n_ovf != 0 || n_vcyc != 0) begin
            miscompares++; $display("FAIL len_err_empty got len=%0d other=%0d valid=%0d exp=1/0/0", n_len, n_crc + n_ch + n_ovf, n_vcyc); end
        clear_mon();
        pl_q = {};
        for (int i = 0; i < 9; i++) pl_q.push_back(16'h1000 + 16'(i));
        send_frame(1'b0, 1'b0); idle(4);
        vectors++; if (n_len != 1 || n_crc + n_ch + n_ovf != 0 || n_vcyc != 0) begin
            miscompares++; $display("FAIL len_err_overflow got len=%0d other=%0d valid=%0d exp=1/0/0", n_len, n_crc + n_ch + n_ovf, n_vcyc); end
        clear_mon();
        pl_q = {16'h2222};
        send_frame(1'b0, 1'b0); idle(4);
        vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL hunt_after_overflow got results=%0d exp=1", got_q.size()); end
    endtask

    task automatic test_backpressure();
        res_t ea;
        clear_mon(); out_ready = 1'b0;
        cur_ch = 16'h0001; pl_q = {16'h0101, 16'h0202, 16'h0303}; crc_x = 16'h0;
        ea = model_res();
        send_frame(1'b0, 1'b0); idle(2);
        cur_ch = 16'h0002; pl_q = {16'h0404, 16'h0505};
        send_frame(1'b0, 1'b0); idle(3);
        vectors++; if (n_ovf != 1 || n_crc + n_len + n_ch != 0) begin miscompares++; $display("FAIL bp_ovf_pulse got ovf=%0d other=%0d exp=1/0", n_ovf, n_crc + n_len + n_ch); end
        vectors++; if (out_valid !== 1'b1 || {out_data, out_ch, out_len} !== ea) begin
            miscompares++; $display("FAIL bp_held got valid=%b res=%h exp=1 %h", out_valid, {out_data, out_ch, out_len}, ea); end
        out_ready = 1'b1; idle(3);
        vectors++; if (got_q.size() != 1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_consume got results=%0d valid=%b exp=1/0", got_q.size(), out_valid); end
        else begin vectors++; if (got_q[0] !== ea) begin miscompares++; $display("FAIL bp_consumed_result got=%h exp=%h", got_q[0], ea); end end
    endtask

    task automatic test_back_to_back();
        res_t ea, eb;
        clear_mon(); out_ready = 1'b0;
        cur_ch = 16'h0004; pl_q = {16'h4444}; crc_x = 16'h0;
        ea = model_res();
        send_frame(1'b0, 1'b0); idle(2);
        cur_ch = 16'h0006; pl_q = {16'h6666, 16'h7777, 16'h8888, 16'h9999};
        eb = model_res();
        send_frame(1'b0, 1'b1); idle(4);
        vectors++; if (got_q.size() != 2 || n_ovf != 0) begin miscompares++; $display("FAIL b2b_count got results=%0d ovf=%0d exp=2/0", got_q.size(), n_ovf); end
        else begin
            vectors++; if (got_q[0] !== ea || got_q[1] !== eb) begin
                miscompares++; $display("FAIL b2b_results got=%h,%h exp=%h,%h", got_q[0], got_q[1], ea, eb); end
        end
    endtask

    task automatic test_stall_and_hdr();
        res_t ea;
        clear_mon(); out_ready = 1'b1;
        cur_ch = 16'h0007; pl_q = {16'hCAFE, 16'hBEEF, 16'h0001, 16'h8000}; crc_x = 16'h0;
        ea = model_res();
        send_frame(1'b1, 1'b0); idle(4);
        vectors++; if (got_q.size() != 1 || n_crc + n_len + n_ch + n_ovf != 0) begin
            miscompares++; $display("FAIL stall_count got results=%0d errs=%0d exp=1/0", got_q.size(), n_crc + n_len + n_ch + n_ovf); end
        else begin vectors++; if (got_q[0] !== ea) begin miscompares++; $display("FAIL stall_result got=%h exp=%h", got_q[0], ea); end end
        clear_mon();
        cur_ch = 16'h0009; pl_q = {16'hE0E0, 16'hE0E0, 16'hABCD};
        ea = model_res();
        send_frame(1'b0, 1'b0); idle(4);
        vectors++; if (got_q.size() != 1 || n_crc + n_len + n_ch + n_ovf != 0) begin
            miscompares++; $display("FAIL hdr_payload_count got results=%0d errs=%0d exp=1/0", got_q.size(), n_crc + n_len + n_ch + n_ovf); end
        else begin vectors++; if (got_q[0] !== ea) begin miscompares++; $display("FAIL hdr_payload_result got=%h exp=%h", got_q[0], ea); end end
    endtask

    task automatic test_reset_mid();
        res_t ea;
        logic [15:0] part[$];
        clear_mon(); out_ready = 1'b1;
        part = {HDR, HDR, 16'h0003, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
        foreach (part[i]) push(part[i], 1'b0);
        rst = 1'b1; idle(2); rst = 1'b0; idle(2);
        vectors++; if (n_rsterr + n_crc + n_len + n_ch + n_ovf + n_vcyc != 0 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid_quiet got events=%0d valid=%b exp=0/0", n_rsterr + n_crc + n_len + n_ch + n_ovf + n_vcyc, out_valid); end
        cur_ch = 16'h0005; pl_q = {16'hAAAA}; crc_x = 16'h0;
        ea = model_res();
        send_frame(1'b0, 1'b0); idle(4);
        vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL reset_mid_next_count got=%0d exp=1", got_q.size()); end
        else begin vectors++; if (got_q[0] !== ea) begin miscompares++; $display("FAIL reset_mid_next_result got=%h exp=%h", got_q[0], ea); end end
    endtask

    task automatic test_random();
        int   n, kind;
        bit   stall;
        res_t ea;
        out_ready = 1'b1;
        for (int f = 0; f < 24; f++) begin
            clear_mon();
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(1, 8));
            cur_ch = 16'($urandom);
            cur_ch[7:0] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            crc_x = ($urandom_range(0, 3) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
            do begin
                pl_q = {};
                for (int i = 0; i < n; i++) begin
                    logic [15:0] w;
                    do w = 16'($urandom); while (w == TAIL);
                    pl_q.push_back(w);
                end
            end while ((model_crc() ^ crc_x) == TAIL);
            kind  = model_kind();
            stall = 1'($urandom_range(0, 1));
            ea    = model_res();
            send_frame(stall, 1'b0); idle(4);
            vectors++;
            if (n_len != int'(kind == 1) || n_ch != int'(kind == 2) || n_crc != int'(kind == 3) || n_ovf != 0 || got_q.size() != int'(kind == 0)) begin
                miscompares++;
                $display("FAIL rand_events frame=%0d got len=%0d ch=%0d crc=%0d ovf=%0d res=%0d exp kind=%0d n=%0d", f, n_len, n_ch, n_crc, n_ovf, got_q.size(), kind, n);
            end else if (kind == 0) begin
                vectors++; if (got_q[0] !== ea) begin miscompares++; $display("FAIL rand_result frame=%0d got=%h exp=%h", f, got_q[0], ea); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_crc_err();
        test_ch_len();
        test_backpressure();
        test_back_to_back();
        test_stall_and_hdr();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_parser_mc.md
FRAME_PARSER_MC -- requirements
Module: frame_parser_mc

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- W, 16, stream word width
- MAX_WORDS, 8, maximum payload words per frame
- NUM_CH, 16, number of legal channels
- CH_W, 8, channel-id width taken from the low bits of the channel word
- HDR_PAT, 16'hE0E0, header word; two consecutive words form the header
- TAIL_PAT, 16'h0E0E, tail word; two consecutive words form the tail
- CRC_POLY, 16'h1021, CRC polynomial
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_in, in, 1, single clock; all logic is on the rising edge
- rst, in, 1, reset, synchronous active-high
- data_in, in, W, stream word
- data_valid, in, 1, data_in is accepted on every edge where this is high
- out_data, out, MAX_WORDS*W, payload, first word at the MSB end, unused bits zero
- out_ch, out, CH_W, channel id
- out_len, out, $clog2(MAX_WORDS+1), payload word count
- out_valid, out, 1, result valid
- out_ready, in, 1, consumer accepts the result
- crc_err, out, 1, one-cycle pulse
- len_err, out, 1, one-cycle pulse
- ch_err, out, 1, one-cycle pulse
- ovf_err, out, 1, one-cycle pulse

Function
REQ-003 The frame format SHALL be: HDR HDR CH P0..P(n-1) CRC TAIL TAIL, with 1 <= n <= MAX_WORDS. Only accepted words (data_valid=1) count toward this format.
REQ-004 The FSM SHALL have four states: HUNT, CHAN, BODY, DONE.
- HUNT -> CHAN after two consecutive accepted HDR_PAT words.
- CHAN -> BODY on the next accepted word, which is latched as the channel word.
- BODY -> DONE when the last two accepted words equal TAIL_PAT.
- DONE -> HUNT unconditionally after one cycle.
REQ-005 In BODY, accepted words SHALL pass through a 3-word delay line. A word leaving the delay line is a payload word: it is appended to the payload, fed to the CRC, and increments the count.
REQ-006 At the tail, the word immediately before the two tail words SHALL be the received CRC.
REQ-007 The CRC SHALL be computed MSB-first over payload words only, with init 16'h0000, using CRC_POLY and no final XOR.
REQ-008 In DONE, the block SHALL evaluate the frame in this priority: len_err (n=0), ch_err (CH[CH_W-1:0] >= NUM_CH), crc_err (mismatch). Exactly one pulse is produced, or none if the frame is good.
REQ-009 If the payload count would exceed MAX_WORDS before the tail is seen, the block SHALL pulse len_err and return to HUNT on that same edge.
REQ-010 For a good frame, out_valid SHALL rise in the cycle after the edge that accepted the second tail word. out_data, out_ch and out_len are loaded on that same edge.
REQ-011 out_valid SHALL stay high, with outputs stable, until an edge where out_valid && out_ready; out_valid falls on that edge.
REQ-012 If a good frame completes while out_valid=1 and out_ready=0, the new frame SHALL be dropped, the held result is unchanged, and ovf_err pulses.
REQ-013 If a good frame completes in the same cycle that the held result is accepted, the new result SHALL load and out_valid stays high.
REQ-014 data_valid=0 SHALL stall all parsing; the state and delay line are held.
REQ-015 The tail SHALL only be recognised in BODY. HDR_PAT words inside the payload SHALL be treated as data.
REQ-016 Parsing of a new frame SHALL start in HUNT only; a header seen during BODY is not recognised.

Reset
REQ-017 While rst=1 on an edge, the FSM SHALL go to HUNT, and the delay line, CRC, count, out_data, out_ch, out_len and out_valid SHALL clear to 0.
REQ-018 While rst=1, all error pulses SHALL be 0.
REQ-019 Reset asserted mid-frame SHALL discard the frame without any error pulse.

Configuration
REQ-020 With FRAME_PARSER_MC_STATS_EN defined, the block SHALL add two 16-bit outputs:
- frame_ok_cnt: counts good frames loaded into the output.
- frame_err_cnt: counts every err pulse.
- Both wrap at 16'hFFFF -> 0 and clear on reset.
REQ-021 Without FRAME_PARSER_MC_STATS_EN, these ports and their counters SHALL not exist.

Structure
REQ-022 Package frame_parser_pkg SHALL hold the FSM state enum and the default HDR_PAT, TAIL_PAT and CRC_POLY constants.
REQ-023 The CRC update SHALL be a separate combinational sub-module, crc_word_step (inputs crc, word, poly; output next crc), instantiated once.

Verification
REQ-024 Directed scenario, good frame: CH=16'h0003, payload 16'h1234,16'h5678, correct CRC, out_ready=1 -> one-cycle out_valid, out_ch=8'h03, out_len=2, out_data top 32 bits = 32'h12345678, rest zero.
REQ-025 Directed scenario, corrupted CRC: same frame with CRC^16'h0001 -> crc_err single pulse, no out_valid.
REQ-026 Directed scenario, channel and length errors:
- CH=16'h0010 (NUM_CH=16) -> ch_err pulse.
- Header, CH, CRC, tail with no payload -> len_err.
- 9 payload words -> len_err before the tail, then FSM in HUNT.
REQ-027 Directed scenario, backpressure: two good frames back-to-back with out_ready=0 -> first result held, ovf_err pulse on second. Then set out_ready=1 -> first result consumed.
REQ-028 Directed scenario, stalls: good frame with data_valid toggling 1/0 every cycle -> same result as unstalled.
REQ-029 Directed scenario, payload containing HDR_PAT: a payload word 16'hE0E0 -> parsed as data, frame good.
REQ-030 Directed scenario, reset mid-frame: rst pulsed during BODY -> no pulses, no out_valid; a following good frame is parsed correctly.
